// File: rtl/scan_capture.sv
// Loopback receiver for a 4-digit multiplexed 7-segment display. It samples the
// segment and digit-select lines on each scan strobe and rebuilds the four digit codes.
module scan_capture #(
  parameter int unsigned STABLE_N       = 2,
  parameter bit          SEG_ACTIVE_LOW = 1'b0,
  parameter bit          POS_ACTIVE_LOW = 1'b0
) (
  input  logic       clk,
  input  logic       r,
  input  logic       scan,
  input  logic       a,
  input  logic       b,
  input  logic       c,
  input  logic       d,
  input  logic       e,
  input  logic       f,
  input  logic       g,
  input  logic [3:0] pos,
  output logic [3:0] d0,
  output logic [3:0] d1,
  output logic [3:0] d2,
  output logic [3:0] d3,
  output logic [3:0] dvalid,
  output logic       frame_done,
  output logic       err_pos,
  output logic       err_seg,
  output logic       err_seq
);

  typedef enum logic [1:0] {HUNT = 2'd0, EXP1 = 2'd1, EXP2 = 2'd2, EXP3 = 2'd3} state_t;

  localparam logic [2:0] STABLE_C = 3'(STABLE_N);

  // Returns {legal, code}.
  function automatic logic [4:0] glyph_decode(input logic [6:0] s);
    case (s)
      7'b1111110: glyph_decode = 5'h10;
      7'b0110000: glyph_decode = 5'h11;
      7'b1101101: glyph_decode = 5'h12;
      7'b1111001: glyph_decode = 5'h13;
      7'b0110011: glyph_decode = 5'h14;
      7'b1011011: glyph_decode = 5'h15;
      7'b1011111: glyph_decode = 5'h16;
      7'b1110000: glyph_decode = 5'h17;
      7'b1111111: glyph_decode = 5'h18;
      7'b1111011: glyph_decode = 5'h19;
      7'b1110111: glyph_decode = 5'h1A;
      7'b0011111: glyph_decode = 5'h1B;
      7'b1001110: glyph_decode = 5'h1C;
      7'b0111101: glyph_decode = 5'h1D;
      7'b1001111: glyph_decode = 5'h1E;
      7'b1000111: glyph_decode = 5'h1F;
      default:    glyph_decode = 5'h00;
    endcase
  endfunction

  function automatic logic [1:0] pos_index(input logic [3:0] p);
    case (p)
      4'b0010: pos_index = 2'd1;
      4'b0100: pos_index = 2'd2;
      4'b1000: pos_index = 2'd3;
      default: pos_index = 2'd0;
    endcase
  endfunction

  function automatic logic [2:0] sat_inc(input logic [2:0] v);
    sat_inc = (v < STABLE_C) ? v + 3'd1 : v;
  endfunction

  logic            vld_p1_q, vld_p1_d;
  logic [6:0]      seg_p1_q, seg_p1_d;
  logic [3:0]      pos_p1_q, pos_p1_d;

  state_t          state_q, state_d;
  logic [3:0][3:0] cand_q, cand_d;
  logic [3:0][2:0] cnt_q, cnt_d;
  logic [3:0][3:0] dig_q, dig_d;
  logic [3:0]      dvalid_q, dvalid_d;
  logic            frame_done_q, frame_done_d;
  logic            err_pos_q, err_pos_d;
  logic            err_seg_q, err_seg_d;
  logic            err_seq_q, err_seq_d;

  logic            pos_onehot;
  logic [1:0]      idx;
  logic [4:0]      gl;
  logic [2:0]      cnt_nx;

  // ---- stage p0 -> p1: polarity-corrected sample on the scan strobe ----
  always_comb begin
    vld_p1_d = scan;
    seg_p1_d = seg_p1_q;
    pos_p1_d = pos_p1_q;
    if (scan) begin
      seg_p1_d = {a, b, c, d, e, f, g} ^ {7{SEG_ACTIVE_LOW}};
      pos_p1_d = pos ^ {4{POS_ACTIVE_LOW}};
    end
  end

  assign pos_onehot = (pos_p1_q != 4'd0) && ((pos_p1_q & (pos_p1_q - 4'd1)) == 4'd0);

  // ---- stage p1 -> p2: decode, per-digit filter and frame tracking ----
  always_comb begin
    state_d      = state_q;
    cand_d       = cand_q;
    cnt_d        = cnt_q;
    dig_d        = dig_q;
    dvalid_d     = dvalid_q;
    frame_done_d = 1'b0;
    err_pos_d    = 1'b0;
    err_seg_d    = 1'b0;
    err_seq_d    = 1'b0;
    idx          = pos_index(pos_p1_q);
    gl           = glyph_decode(seg_p1_q);
    cnt_nx       = sat_inc(cnt_q[idx]);
    if (vld_p1_q) begin
      if (!pos_onehot) begin
        err_pos_d = 1'b1;
        state_d   = HUNT;
      end else begin
        if (!gl[4]) begin
          err_seg_d  = 1'b1;
          cnt_d[idx] = 3'd0;
        end else if (gl[3:0] == cand_q[idx]) begin
          cnt_d[idx] = cnt_nx;
          if (cnt_nx == STABLE_C) begin
            dig_d[idx]    = gl[3:0];
            dvalid_d[idx] = 1'b1;
          end
        end else begin
          cand_d[idx] = gl[3:0];
          cnt_d[idx]  = 3'd1;
          if (STABLE_C == 3'd1) begin
            dig_d[idx]    = gl[3:0];
            dvalid_d[idx] = 1'b1;
          end
        end
        // Sequence tracking looks only at the position, never at the glyph.
        if (state_q == HUNT) begin
          if (idx == 2'd0) state_d = EXP1;
        end else if (idx == 2'(state_q)) begin
          if (idx == 2'd3) begin
            state_d      = HUNT;
            frame_done_d = 1'b1;
          end else begin
            state_d = state_t'(idx + 2'd1);
          end
        end else begin
          err_seq_d = 1'b1;
          state_d   = (idx == 2'd0) ? EXP1 : HUNT;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge r) begin
    if (!r) begin
      vld_p1_q     <= 1'b0;
      seg_p1_q     <= '0;
      pos_p1_q     <= '0;
      state_q      <= HUNT;
      cand_q       <= '0;
      cnt_q        <= '0;
      dig_q        <= '0;
      dvalid_q     <= '0;
      frame_done_q <= 1'b0;
      err_pos_q    <= 1'b0;
      err_seg_q    <= 1'b0;
      err_seq_q    <= 1'b0;
    end else begin
      vld_p1_q     <= vld_p1_d;
      seg_p1_q     <= seg_p1_d;
      pos_p1_q     <= pos_p1_d;
      state_q      <= state_d;
      cand_q       <= cand_d;
      cnt_q        <= cnt_d;
      dig_q        <= dig_d;
      dvalid_q     <= dvalid_d;
      frame_done_q <= frame_done_d;
      err_pos_q    <= err_pos_d;
      err_seg_q    <= err_seg_d;
      err_seq_q    <= err_seq_d;
    end
  end

  assign d0         = dig_q[0];
  assign d1         = dig_q[1];
  assign d2         = dig_q[2];
  assign d3         = dig_q[3];
  assign dvalid     = dvalid_q;
  assign frame_done = frame_done_q;
  assign err_pos    = err_pos_q;
  assign err_seg    = err_seg_q;
  assign err_seq    = err_seq_q;

endmodule

// File: tb/tb_scan_capture.sv
// Directed bench for scan_capture: samples are scored against a queue of expected
// output snapshots, plus direct checks at the interesting points.
module tb_scan_capture;

  localparam int SN = 2;

  logic       clk = 1'b0;
  logic       r;
  logic       scan;
  logic [6:0] seg;
  logic [3:0] pos;

  logic [3:0] d0, d1, d2, d3, dvalid;
  logic       frame_done, err_pos, err_seg, err_seq;
  logic [3:0] d0_2, d1_2, d2_2, d3_2, dvalid_2;
  logic       frame_done_2, err_pos_2, err_seg_2, err_seq_2;

  int total = 0;
  int bad   = 0;

  logic [6:0] GLY [16] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                           7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                           7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
                           7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};

  typedef struct packed {
    logic [3:0][3:0] dig;
    logic [3:0]      dv;
    logic            fd;
    logic            ep;
    logic            es;
    logic            eq;
  } exp_t;

  exp_t q[$];
  exp_t hold;

  // reference model state
  int         m_st;
  int         m_cnt [4];
  logic [3:0] m_cand [4];
  logic [3:0] m_dig [4];
  logic [3:0] m_dv;

  logic s1, s2;

  scan_capture #(.STABLE_N(SN), .SEG_ACTIVE_LOW(1'b0), .POS_ACTIVE_LOW(1'b0)) dut (
    .clk(clk), .r(r), .scan(scan),
    .a(seg[6]), .b(seg[5]), .c(seg[4]), .d(seg[3]), .e(seg[2]), .f(seg[1]), .g(seg[0]),
    .pos(pos), .d0(d0), .d1(d1), .d2(d2), .d3(d3), .dvalid(dvalid),
    .frame_done(frame_done), .err_pos(err_pos), .err_seg(err_seg), .err_seq(err_seq)
  );

  scan_capture #(.STABLE_N(SN), .SEG_ACTIVE_LOW(1'b1), .POS_ACTIVE_LOW(1'b0)) dut_al (
    .clk(clk), .r(r), .scan(scan),
    .a(~seg[6]), .b(~seg[5]), .c(~seg[4]), .d(~seg[3]), .e(~seg[2]), .f(~seg[1]), .g(~seg[0]),
    .pos(pos), .d0(d0_2), .d1(d1_2), .d2(d2_2), .d3(d3_2), .dvalid(dvalid_2),
    .frame_done(frame_done_2), .err_pos(err_pos_2), .err_seg(err_seg_2), .err_seq(err_seq_2)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cmp_out(input string w, input exp_t x);
    check({w, ".d0"}, 32'(d0), 32'(x.dig[0]));
    check({w, ".d1"}, 32'(d1), 32'(x.dig[1]));
    check({w, ".d2"}, 32'(d2), 32'(x.dig[2]));
    check({w, ".d3"}, 32'(d3), 32'(x.dig[3]));
    check({w, ".dvalid"}, 32'(dvalid), 32'(x.dv));
    check({w, ".frame_done"}, 32'(frame_done), 32'(x.fd));
    check({w, ".err_pos"}, 32'(err_pos), 32'(x.ep));
    check({w, ".err_seg"}, 32'(err_seg), 32'(x.es));
    check({w, ".err_seq"}, 32'(err_seq), 32'(x.eq));
  endtask

  task automatic m_reset();
    m_st = 0;
    m_dv = 4'd0;
    for (int i = 0; i < 4; i++) begin
      m_cnt[i]  = 0;
      m_cand[i] = 4'd0;
      m_dig[i]  = 4'd0;
    end
    hold = '0;
    q.delete();
  endtask

  // Model of one accepted sample; returns the output snapshot it should produce.
  task automatic model(input logic [3:0] p, input logic [6:0] s, output exp_t x);
    int   k;
    bit   legal;
    logic [3:0] code;
    x = '0;
    k = 0;
    legal = 1'b0;
    code = 4'd0;
    if ($countones(p) != 1) begin
      x.ep = 1'b1;
      m_st = 0;
    end else begin
      for (int i = 0; i < 4; i++) if (p[i]) k = i;
      for (int cc = 0; cc < 16; cc++) if (GLY[cc] == s) begin legal = 1'b1; code = 4'(cc); end
      if (!legal) begin
        x.es = 1'b1;
        m_cnt[k] = 0;
      end else if (code == m_cand[k]) begin
        if (m_cnt[k] < SN) m_cnt[k] = m_cnt[k] + 1;
        if (m_cnt[k] == SN) begin m_dig[k] = code; m_dv[k] = 1'b1; end
      end else begin
        m_cand[k] = code;
        m_cnt[k]  = 1;
        if (SN == 1) begin m_dig[k] = code; m_dv[k] = 1'b1; end
      end
      if (m_st == 0) begin
        if (k == 0) m_st = 1;
      end else if (k == m_st) begin
        if (k == 3) begin m_st = 0; x.fd = 1'b1; end
        else m_st = m_st + 1;
      end else begin
        x.eq = 1'b1;
        m_st = (k == 0) ? 1 : 0;
      end
    end
    for (int i = 0; i < 4; i++) x.dig[i] = m_dig[i];
    x.dv = m_dv;
  endtask

  task automatic smp(input logic [3:0] p, input logic [6:0] s);
    exp_t x;
    @(negedge clk);
    pos  = p;
    seg  = s;
    scan = 1'b1;
    model(p, s, x);
    q.push_back(x);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      scan = 1'b0;
    end
  endtask

  task automatic frame(input int c0, input int c1, input int c2, input int c3);
    int cs [4];
    cs = '{c0, c1, c2, c3};
    for (int i = 0; i < 4; i++) begin
      smp(4'(1 << i), GLY[cs[i]]);
      idle(3);
    end
  endtask

  always @(posedge clk or negedge r) begin
    if (!r) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= scan;
      s2 <= s1;
    end
  end

  // Output monitor: score a snapshot two edges after each sample, else expect quiet outputs.
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      if (r === 1'b1) begin
        if (s2) begin
          if (q.size() == 0) begin
            check("sb.underflow", 32'd1, 32'd0);
          end else begin
            x = q.pop_front();
            cmp_out("sb", x);
            hold = x;
            hold.fd = 1'b0;
            hold.ep = 1'b0;
            hold.es = 1'b0;
            hold.eq = 1'b0;
          end
        end else begin
          cmp_out("quiet", hold);
        end
      end
    end
  end

  initial begin
    r    = 1'b0;
    scan = 1'b0;
    seg  = 7'd0;
    pos  = 4'd0;
    m_reset();
    repeat (3) @(negedge clk);
    cmp_out("rst", '0);
    r = 1'b1;
    idle(10);

    // 1: mid-frame asynchronous reset, then idle
    smp(4'b0001, GLY[7]); idle(1);
    smp(4'b0001, GLY[7]); idle(3);
    smp(4'b0010, GLY[9]); idle(3);
    check("pre_rst.d0", 32'(d0), 32'd7);
    check("pre_rst.dv", 32'(dvalid), 32'b0001);
    @(negedge clk);
    #2 r = 1'b0;
    m_reset();
    #1 cmp_out("async_rst", '0);
    @(negedge clk);
    r = 1'b1;
    idle(10);
    cmp_out("post_rst_idle", '0);

    // 2: "1234" for two frames
    frame(1, 2, 3, 4);
    check("f1.dvalid", 32'(dvalid), 32'd0);
    frame(1, 2, 3, 4);
    check("f2.d0", 32'(d0), 32'd1);
    check("f2.d1", 32'(d1), 32'd2);
    check("f2.d2", 32'(d2), 32'd3);
    check("f2.d3", 32'(d3), 32'd4);
    check("f2.dvalid", 32'(dvalid), 32'hF);

    // 3: stability filter on position 1
    frame(1, 5, 3, 4);
    frame(1, 5, 3, 4);
    check("t3.d1_5", 32'(d1), 32'd5);
    frame(1, 6, 3, 4);
    check("t3.glitch6", 32'(d1), 32'd5);
    frame(1, 5, 3, 4);
    check("t3.back5a", 32'(d1), 32'd5);
    frame(1, 5, 3, 4);
    check("t3.back5b", 32'(d1), 32'd5);
    frame(1, 6, 3, 4);
    check("t3.first6", 32'(d1), 32'd5);
    smp(4'b0001, GLY[1]); idle(3);
    smp(4'b0010, GLY[6]);
    idle(1);
    check("t3.second6_early", 32'(d1), 32'd5);
    idle(1);
    check("t3.second6", 32'(d1), 32'd6);
    idle(1);
    smp(4'b0100, GLY[3]); idle(3);
    smp(4'b1000, GLY[4]); idle(3);

    // 4: illegal glyph on position 2
    smp(4'b0001, GLY[1]); idle(3);
    smp(4'b0010, GLY[6]); idle(3);
    smp(4'b0100, 7'b0000001); idle(2);
    check("t4.err_seg", 32'(err_seg), 32'd1);
    idle(1);
    check("t4.d2", 32'(d2), 32'd3);
    check("t4.dv2", 32'(dvalid[2]), 32'd1);
    smp(4'b1000, GLY[4]); idle(2);
    check("t4.frame_done", 32'(frame_done), 32'd1);
    idle(1);

    // 5: bad position code
    smp(4'b0101, GLY[0]); idle(2);
    check("t5.err_pos", 32'(err_pos), 32'd1);
    idle(1);
    smp(4'b0010, GLY[6]); idle(2);
    check("t5.no_err_seq", 32'(err_seq), 32'd0);
    idle(1);
    frame(1, 6, 3, 4);

    // 6: out-of-order position, back-to-back samples, active-low segments
    smp(4'b0001, GLY[1]); idle(3);
    smp(4'b0100, GLY[3]); idle(2);
    check("t6.err_seq", 32'(err_seq), 32'd1);
    idle(1);
    smp(4'b0001, GLY[8]);
    smp(4'b0001, GLY[8]);
    idle(3);
    check("t6.d0", 32'(d0), 32'd8);
    check("t6.al.d0", 32'(d0_2), 32'd8);
    check("t6.al.dv0", 32'(dvalid_2[0]), 32'd1);
    for (int rep = 0; rep < 2; rep++) begin
      smp(4'b0001, GLY[10]);
      smp(4'b0010, GLY[11]);
      smp(4'b0100, GLY[12]);
      smp(4'b1000, GLY[13]);
    end
    idle(3);
    check("t6.b2b.d3", 32'(d3), 32'd13);
    check("t6.b2b.d0", 32'(d0), 32'd10);
    check("al.known", 32'($isunknown({d1_2, d2_2, d3_2, dvalid_2, frame_done_2,
                                      err_pos_2, err_seg_2, err_seq_2})), 32'd0);

    idle(5);
    check("sb.drained", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
